// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared definitions for the fetch PC generator.
//   * FSM state encodings (legacy localparam constants plus a matching enum)
//   * default reset fetch address
//   * redirect channel indices, in priority order (0 = highest)
package pc_gen_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   typedef enum logic [1:0] {
      PC_IDLE = ST_IDLE,
      PC_REQ  = ST_REQ,
      PC_WAIT = ST_WAIT
   } pc_state_e;

   localparam int EXCEPT        = 0;
   localparam int PRED_FAIL     = 1;
   localparam int JUMP_CONFLICT = 2;
   localparam int FLUSH_ALL     = 3;
   localparam int D_BRANCH      = 4;
   localparam int D_JUMP        = 5;
   localparam int SPARE         = 6;

endpackage

// File: rtl/pc_gen_redir_arbiter.sv
// redir_arbiter -- fixed-priority select over the redirect channels.
//   req_valid  in  NUM_REDIR       per-channel request
//   req_target in  NUM_REDIR x 32  per-channel target
//   sel_valid  out 1               any channel requesting
//   sel_target out 32              target of the lowest-index requester
module redir_arbiter #(
   parameter int NUM_REDIR = 7
) (
   input  logic [NUM_REDIR-1:0]       req_valid,
   input  logic [NUM_REDIR-1:0][31:0] req_target,
   output logic                       sel_valid,
   output logic [31:0]                sel_target
);

   logic [NUM_REDIR-1:0] grant_s;

   // Isolate the lowest set bit (x & -x) so the grant is one-hot and the
   // target mux reduces to an AND-OR tree.
   assign grant_s   = req_valid & (~req_valid + NUM_REDIR'(1));
   assign sel_valid = |req_valid;

   // AND-OR mux of the granted channel's target.
   always_comb begin
      sel_target = 32'h0000_0000;
      for (int i = 0; i < NUM_REDIR; i++) begin
         sel_target = sel_target | (req_target[i] & {32{grant_s[i]}});
      end
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- fetch program-counter generator.
// Issues one fetch request per group, advances the PC by the number of
// instructions returned (clamped to the cache line), and applies prioritised
// redirects. A redirect that overtakes an in-flight request marks that
// response for discard.
//   clk, rst               clock, synchronous active-high reset
//   redir_valid/target     redirect channels (index 0 highest priority)
//   fifo_full              blocks new requests only
//   inst_req/addr/max_cnt  request side; inst_addr_ok acknowledges
//   inst_data_ok/data_cnt  response side
//   fetch_valid/fetch_pc   accepted group forwarded to the fetch FIFO
//   pc_curr/pc_next        registered and next PC
//   redir_pending          in-flight response will be discarded
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int          FETCH_WIDTH = 2,
   parameter int          NUM_REDIR   = 7,
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          LINE_BYTES  = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REDIR-1:0]               redir_valid,
   input  logic [NUM_REDIR-1:0][31:0]         redir_target,
   input  logic                               fifo_full,
   output logic                               inst_req,
   output logic [31:0]                        inst_addr,
   output logic [$clog2(FETCH_WIDTH+1)-1:0]   inst_max_cnt,
   input  logic                               inst_addr_ok,
   input  logic                               inst_data_ok,
   input  logic [$clog2(FETCH_WIDTH+1)-1:0]   inst_data_cnt,
   output logic                               fetch_valid,
   output logic [31:0]                        fetch_pc,
   output logic [31:0]                        pc_curr,
   output logic [31:0]                        pc_next,
   output logic                               redir_pending
);

   localparam int CW = $clog2(FETCH_WIDTH + 1);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [31:0]   pc_curr_r;
   logic [31:0]   pc_adv_s;
   logic [31:0]   pc_next_s;
   logic          discard_r;
   logic          discard_nxt_s;
   logic          fetch_valid_s;
   logic          redir_any_s;
   logic [31:0]   redir_tgt_s;
   logic [31:0]   line_off_s;
   logic [31:0]   room_s;
   logic [CW-1:0] max_cnt_s;
   logic [CW-1:0] take_s;
   logic [31:0]   step_s;

   redir_arbiter #(
      .NUM_REDIR (NUM_REDIR)
   ) u_arb (
      .req_valid  (redir_valid),
      .req_target (redir_target),
      .sel_valid  (redir_any_s),
      .sel_target (redir_tgt_s)
   );

   // Slots left in the current line, computed by masking rather than slicing
   // so a 4-byte line still elaborates.
   assign line_off_s = pc_curr_r & 32'(LINE_BYTES - 1);
   assign room_s     = (32'(LINE_BYTES) - line_off_s) >> 2;

   // Clamp the line room to the fetch width.
   always_comb begin
      if (room_s < 32'(FETCH_WIDTH)) begin
         max_cnt_s = room_s[CW-1:0];
      end else begin
         max_cnt_s = CW'(FETCH_WIDTH);
      end
   end

   // Instructions actually consumed: never more than the line allows.
   always_comb begin
      if (inst_data_cnt < max_cnt_s) begin
         take_s = inst_data_cnt;
      end else begin
         take_s = max_cnt_s;
      end
   end

   assign step_s = {{(30 - CW){1'b0}}, take_s, 2'b00};

   // FSM transitions, discard tracking and response acceptance.
   always_comb begin
      state_nxt_s   = state_r;
      discard_nxt_s = discard_r;
      pc_adv_s      = pc_curr_r;
      fetch_valid_s = 1'b0;
      if (rst) begin
         state_nxt_s   = ST_IDLE;
         discard_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_full) begin
                  state_nxt_s = ST_REQ;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_REQ: begin
               if (inst_addr_ok) begin
                  // The accepted request was for the old PC if a redirect
                  // lands in the same cycle.
                  state_nxt_s   = ST_WAIT;
                  discard_nxt_s = redir_any_s;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (inst_data_ok) begin
                  state_nxt_s   = fifo_full ? ST_IDLE : ST_REQ;
                  discard_nxt_s = 1'b0;
                  if (!discard_r && !redir_any_s && (take_s != '0)) begin
                     fetch_valid_s = 1'b1;
                     pc_adv_s      = pc_curr_r + step_s;
                  end else begin
                     fetch_valid_s = 1'b0;
                     pc_adv_s      = pc_curr_r;
                  end
               end else if (redir_any_s) begin
                  discard_nxt_s = 1'b1;
               end else begin
                  discard_nxt_s = discard_r;
               end
            end
            default: begin
               state_nxt_s   = ST_IDLE;
               discard_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // Next-PC priority: reset, then redirect, then accepted response.
   always_comb begin
      if (rst) begin
         pc_next_s = RESET_PC;
      end else if (redir_any_s) begin
         pc_next_s = redir_tgt_s;
      end else begin
         pc_next_s = pc_adv_s;
      end
   end

   // State, PC and discard registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pc_curr_r <= RESET_PC;
         discard_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pc_curr_r <= pc_next_s;
         discard_r <= discard_nxt_s;
      end
   end

   assign inst_req      = (state_r == ST_REQ);
   assign inst_addr     = pc_curr_r;
   assign inst_max_cnt  = max_cnt_s;
   assign fetch_valid   = fetch_valid_s;
   assign fetch_pc      = pc_curr_r;
   assign pc_curr       = pc_curr_r;
   assign pc_next       = pc_next_s;
   assign redir_pending = discard_r;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
   import pc_gen_pkg::*;

   logic             clk;
   logic             rst;
   logic [6:0]       redir_valid;
   logic [6:0][31:0] redir_target;
   logic             fifo_full;
   logic             inst_req;
   logic [31:0]      inst_addr;
   logic [1:0]       inst_max_cnt;
   logic             inst_addr_ok;
   logic             inst_data_ok;
   logic [1:0]       inst_data_cnt;
   logic             fetch_valid;
   logic [31:0]      fetch_pc;
   logic [31:0]      pc_curr;
   logic [31:0]      pc_next;
   logic             redir_pending;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] nxt;
   } exp_t;
   exp_t sb[$];

   pc_gen dut (
      .clk           (clk),
      .rst           (rst),
      .redir_valid   (redir_valid),
      .redir_target  (redir_target),
      .fifo_full     (fifo_full),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_max_cnt  (inst_max_cnt),
      .inst_addr_ok  (inst_addr_ok),
      .inst_data_ok  (inst_data_ok),
      .inst_data_cnt (inst_data_cnt),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc),
      .pc_curr       (pc_curr),
      .pc_next       (pc_next),
      .redir_pending (redir_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Scoreboard: every forwarded group must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && fetch_valid) begin
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: fetch_pc=%h with no expected group", fetch_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (fetch_pc !== e.pc || pc_next !== e.nxt)
               $display("FAIL sb_group: got pc=%h next=%h want pc=%h next=%h",
                        fetch_pc, pc_next, e.pc, e.nxt);
            else
               n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      redir_valid   = 7'b0;
      redir_target  = '0;
      inst_addr_ok  = 1'b0;
      inst_data_ok  = 1'b0;
      inst_data_cnt = 2'd0;
   endtask

   // Reset, then park in IDLE (fifo_full) and redirect to the given PC.
   task automatic go_idle_at(input logic [31:0] pc);
      clear_inputs();
      rst       = 1'b1;
      fifo_full = 1'b1;
      tick();
      tick();
      rst                  = 1'b0;
      redir_valid[SPARE]   = 1'b1;
      redir_target[SPARE]  = pc;
      tick();
      clear_inputs();
   endtask

   // From REQ: accept the request for one cycle, landing in WAIT.
   task automatic accept_req();
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      fifo_full          = 1'b0;
      rst                = 1'b1;
      redir_valid        = 7'b1111111;
      redir_target[0]    = 32'h1234_5678;
      inst_data_ok       = 1'b1;
      inst_data_cnt      = 2'd2;
      #1;
      n_total++;
      if (pc_next !== 32'hbfc00000) $display("FAIL rst_pc_next: got %h want bfc00000", pc_next);
      else n_pass++;
      tick();
      tick();
      clear_inputs();
      rst = 1'b0;
      n_total++;
      if (pc_curr !== 32'hbfc00000 || inst_req !== 1'b0 || redir_pending !== 1'b0 || fetch_valid !== 1'b0)
         $display("FAIL rst_state: got pc=%h req=%b pend=%b fv=%b want bfc00000/0/0/0",
                  pc_curr, inst_req, redir_pending, fetch_valid);
      else n_pass++;
      tick();
      n_total++;
      if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000 || inst_max_cnt !== 2'd2)
         $display("FAIL rst_first_req: got req=%b addr=%h max=%0d want 1/bfc00000/2",
                  inst_req, inst_addr, inst_max_cnt);
      else n_pass++;
   endtask

   task automatic test_line_boundary();
      go_idle_at(32'hbfc0001c);
      n_total++;
      if (inst_max_cnt !== 2'd1 || inst_req !== 1'b0)
         $display("FAIL lb_max_cnt: got max=%0d req=%b want 1/0", inst_max_cnt, inst_req);
      else n_pass++;
      fifo_full = 1'b0;
      tick();
      accept_req();
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd2;
      sb.push_back('{pc: 32'hbfc0001c, nxt: 32'hbfc00020});
      #1;
      n_total++;
      if (fetch_valid !== 1'b1 || pc_next !== 32'hbfc00020 || fetch_pc !== 32'hbfc0001c)
         $display("FAIL lb_resp: got fv=%b next=%h fpc=%h want 1/bfc00020/bfc0001c",
                  fetch_valid, pc_next, fetch_pc);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (pc_curr !== 32'hbfc00020 || inst_req !== 1'b1)
         $display("FAIL lb_after: got pc=%h req=%b want bfc00020/1", pc_curr, inst_req);
      else n_pass++;
   endtask

   task automatic test_redirect_wait();
      go_idle_at(32'hbfc00040);
      fifo_full = 1'b0;
      tick();
      accept_req();
      redir_valid                 = 7'b0000110;
      redir_target[PRED_FAIL]     = 32'h80000100;
      redir_target[JUMP_CONFLICT] = 32'h80000200;
      #1;
      n_total++;
      if (pc_next !== 32'h80000100) $display("FAIL rw_prio: got %h want 80000100", pc_next);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (pc_curr !== 32'h80000100 || redir_pending !== 1'b1 || inst_req !== 1'b0)
         $display("FAIL rw_pending: got pc=%h pend=%b req=%b want 80000100/1/0",
                  pc_curr, redir_pending, inst_req);
      else n_pass++;
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd2;
      #1;
      n_total++;
      if (fetch_valid !== 1'b0 || pc_next !== 32'h80000100)
         $display("FAIL rw_discard: got fv=%b next=%h want 0/80000100", fetch_valid, pc_next);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (redir_pending !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h80000100)
         $display("FAIL rw_rereq: got pend=%b req=%b addr=%h want 0/1/80000100",
                  redir_pending, inst_req, inst_addr);
      else n_pass++;
   endtask

   task automatic test_redirect_same_cycle();
      accept_req();
      inst_data_ok         = 1'b1;
      inst_data_cnt        = 2'd2;
      redir_valid[EXCEPT]  = 1'b1;
      redir_target[EXCEPT] = 32'hbfc00380;
      #1;
      n_total++;
      if (fetch_valid !== 1'b0 || pc_next !== 32'hbfc00380)
         $display("FAIL sc_resp: got fv=%b next=%h want 0/bfc00380", fetch_valid, pc_next);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (pc_curr !== 32'hbfc00380 || redir_pending !== 1'b0 || inst_req !== 1'b1)
         $display("FAIL sc_after: got pc=%h pend=%b req=%b want bfc00380/0/1",
                  pc_curr, redir_pending, inst_req);
      else n_pass++;
   endtask

   task automatic test_wrap();
      go_idle_at(32'hfffffff8);
      fifo_full = 1'b0;
      tick();
      accept_req();
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd2;
      sb.push_back('{pc: 32'hfffffff8, nxt: 32'h00000000});
      #1;
      n_total++;
      if (pc_next !== 32'h00000000 || inst_max_cnt !== 2'd2)
         $display("FAIL wrap_next: got next=%h max=%0d want 00000000/2", pc_next, inst_max_cnt);
      else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_fifo_full();
      accept_req();
      fifo_full     = 1'b1;
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd1;
      sb.push_back('{pc: 32'h00000000, nxt: 32'h00000004});
      #1;
      n_total++;
      if (fetch_valid !== 1'b1) $display("FAIL ff_forward: got fv=%b want 1", fetch_valid);
      else n_pass++;
      tick();
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (inst_req !== 1'b0 || pc_curr !== 32'h00000004)
            $display("FAIL ff_hold: got req=%b pc=%h want 0/00000004", inst_req, pc_curr);
         else n_pass++;
         tick();
      end
      fifo_full = 1'b0;
      tick();
      n_total++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h00000004)
         $display("FAIL ff_resume: got req=%b addr=%h want 1/00000004", inst_req, inst_addr);
      else n_pass++;
   endtask

   task automatic test_cnt_zero();
      accept_req();
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd0;
      #1;
      n_total++;
      if (fetch_valid !== 1'b0 || pc_next !== 32'h00000004)
         $display("FAIL cz_resp: got fv=%b next=%h want 0/00000004", fetch_valid, pc_next);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (pc_curr !== 32'h00000004 || inst_req !== 1'b1)
         $display("FAIL cz_after: got pc=%h req=%b want 00000004/1", pc_curr, inst_req);
      else n_pass++;
   endtask

   task automatic test_redirect_req();
      redir_valid[FLUSH_ALL]  = 1'b1;
      redir_target[FLUSH_ALL] = 32'h80001000;
      tick();
      clear_inputs();
      n_total++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h80001000 || redir_pending !== 1'b0)
         $display("FAIL rq_noack: got req=%b addr=%h pend=%b want 1/80001000/0",
                  inst_req, inst_addr, redir_pending);
      else n_pass++;
      redir_valid[D_BRANCH]  = 1'b1;
      redir_target[D_BRANCH] = 32'h80002000;
      inst_addr_ok           = 1'b1;
      tick();
      clear_inputs();
      n_total++;
      if (redir_pending !== 1'b1 || pc_curr !== 32'h80002000 || inst_req !== 1'b0)
         $display("FAIL rq_ack: got pend=%b pc=%h req=%b want 1/80002000/0",
                  redir_pending, pc_curr, inst_req);
      else n_pass++;
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd2;
      #1;
      n_total++;
      if (fetch_valid !== 1'b0) $display("FAIL rq_discard: got fv=%b want 0", fetch_valid);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (redir_pending !== 1'b0 || inst_req !== 1'b1 || pc_curr !== 32'h80002000)
         $display("FAIL rq_after: got pend=%b req=%b pc=%h want 0/1/80002000",
                  redir_pending, inst_req, pc_curr);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      accept_req();
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      fifo_full = 1'b1;
      n_total++;
      if (pc_curr !== 32'hbfc00000 || inst_req !== 1'b0 || redir_pending !== 1'b0)
         $display("FAIL rm_state: got pc=%h req=%b pend=%b want bfc00000/0/0",
                  pc_curr, inst_req, redir_pending);
      else n_pass++;
      inst_data_ok  = 1'b1;
      inst_data_cnt = 2'd2;
      #1;
      n_total++;
      if (fetch_valid !== 1'b0 || pc_next !== 32'hbfc00000)
         $display("FAIL rm_stale: got fv=%b next=%h want 0/bfc00000", fetch_valid, pc_next);
      else n_pass++;
      tick();
      clear_inputs();
      n_total++;
      if (pc_curr !== 32'hbfc00000) $display("FAIL rm_after: got pc=%h want bfc00000", pc_curr);
      else n_pass++;
   endtask

   initial begin
      clear_inputs();
      rst       = 1'b1;
      fifo_full = 1'b0;
      test_reset();
      test_line_boundary();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_wrap();
      test_fifo_full();
      test_cnt_zero();
      test_redirect_req();
      test_reset_mid();
      tick();
      n_total++;
      if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, max instructions per fetch group (legal: 1, 2, 4).
REQ-002 SHALL have parameter NUM_REDIR, default 7, number of redirect channels; index 0 is highest priority.
REQ-003 SHALL have parameter RESET_PC, default 32'hbfc00000, reset fetch address.
REQ-004 SHALL have parameter LINE_BYTES, default 32, I-cache line size (power of two, at least 4*FETCH_WIDTH).
REQ-005 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have these ports:
- redir_valid  in  NUM_REDIR  per-channel redirect request.
- redir_target  in  NUM_REDIR x 32  per-channel target.
- fifo_full  in  1  fetch FIFO cannot accept another group.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address, equal to pc_curr.
- inst_max_cnt  out  $clog2(FETCH_WIDTH+1)  slots allowed before the line boundary.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  response valid.
- inst_data_cnt  in  $clog2(FETCH_WIDTH+1)  instructions returned.
- fetch_valid  out  1  response forwarded to the FIFO.
- fetch_pc  out  32  PC of the forwarded group.
- pc_curr  out  32  registered PC.
- pc_next  out  32  combinational next PC.
- redir_pending  out  1  an in-flight response is being discarded.

Function
REQ-007 SHALL implement an FSM with states IDLE, REQ and WAIT.
REQ-008 IDLE SHALL go to REQ when fifo_full=0, and otherwise stay in IDLE.
REQ-009 REQ SHALL drive inst_req=1 and SHALL go to WAIT on inst_addr_ok=1.
REQ-010 WAIT SHALL, on inst_data_ok=1, go to REQ if fifo_full=0, else to IDLE.
REQ-011 inst_max_cnt SHALL equal min(FETCH_WIDTH, (LINE_BYTES - pc_curr mod LINE_BYTES)/4).
REQ-012 On an accepted response (WAIT, inst_data_ok=1, no discard, no redirect), pc_next SHALL be pc_curr + 4*min(inst_data_cnt, inst_max_cnt), wrapping modulo 2^32.
REQ-013 On that response, fetch_valid=1 and fetch_pc=pc_curr SHALL be asserted in the same cycle.
REQ-014 inst_data_cnt=0 SHALL leave the PC unchanged and drive fetch_valid=0, with the FSM still advancing as in REQ-010.
REQ-015 When any redir_valid bit is set, pc_next SHALL be the redir_target of the lowest set index, overriding every other source.
REQ-016 pc_next SHALL equal pc_curr when there is neither a redirect nor an accepted response.
REQ-017 A redirect in WAIT without inst_data_ok SHALL set the discard flag; the FSM SHALL stay in WAIT.
REQ-018 A redirect in REQ with inst_addr_ok=1 SHALL set the discard flag and go to WAIT.
REQ-019 A redirect in REQ without inst_addr_ok SHALL change inst_addr the next cycle; the request SHALL stay asserted.
REQ-020 A redirect in IDLE SHALL update the PC only.
REQ-021 A response arriving while discard=1 SHALL give fetch_valid=0, leave the PC unchanged, and clear discard.
REQ-022 A response arriving in the same cycle as a redirect SHALL give fetch_valid=0; that cycle's redirect target SHALL win.
REQ-023 redir_pending SHALL equal the discard flag.
REQ-024 fifo_full SHALL only gate new requests; a response already in flight SHALL still be forwarded.

Reset
REQ-025 While rst=1, pc_next SHALL equal RESET_PC and all redirect and fetch inputs SHALL be ignored.
REQ-026 The cycle after rst=1, the block SHALL hold pc_curr=RESET_PC, state IDLE, discard=0, inst_req=0, fetch_valid=0, redir_pending=0.
REQ-027 Reset mid-transaction SHALL abandon the in-flight request; a response arriving after reset while in IDLE SHALL be ignored.

Structure
REQ-028 Package pc_gen_pkg SHALL hold the FSM state enum, the default RESET_PC, and the redirect channel index localparams (EXCEPT=0, PRED_FAIL=1, JUMP_CONFLICT=2, FLUSH_ALL=3, D_BRANCH=4, D_JUMP=5, SPARE=6).
REQ-029 A fixed-priority one-hot select sub-module, redir_arbiter, SHALL be parametrised by NUM_REDIR and output a valid bit and a target.

Verification
REQ-030 Reset then idle cache: rst for 2 cycles -> pc_curr=bfc00000, inst_req=1 one cycle after release.
REQ-031 FETCH_WIDTH=2, pc=bfc0001c, addr_ok, then data_ok with cnt=2 -> inst_max_cnt=1, pc_next=bfc00020, fetch_valid=1, fetch_pc=bfc0001c.
REQ-032 In WAIT, redir_valid=0b0000110 (targets 80000100 and 80000200) -> pc_curr=80000100, redir_pending=1; the next data_ok gives fetch_valid=0, then a request to 80000100.
REQ-033 data_ok in the same cycle as redir_valid[0] with target bfc00380 -> fetch_valid=0, pc_curr=bfc00380, no discard set.
REQ-034 pc=fffffff8, FETCH_WIDTH=2, cnt=2 -> pc_next=00000000.
REQ-035 fifo_full=1 on a data_ok cycle -> that group is forwarded, the FSM goes to IDLE, inst_req stays 0 until fifo_full=0.
